// File: rtl/sop_dly_pkg.sv
// Shared types and helpers for the cycle-based AND-OR edge-delay model.
// Event due times are stored zero-extended to DUE_W bits; only DW+1 bits are significant.
package sop_dly_pkg;

  localparam int DUE_W   = 16;
  localparam int MIN_DLY = 1;

  typedef struct packed {
    logic             val;
    logic [DUE_W-1:0] due;
  } dly_event_t;

  typedef enum logic {
    MODE_INERTIAL  = 1'b0,
    MODE_TRANSPORT = 1'b1
  } dly_mode_e;

  // Cycles until an entry fires, modulo the timer period 2^tw.
  function automatic logic [DUE_W-1:0] rem_time(input logic [DUE_W-1:0] due,
                                                input logic [DUE_W-1:0] now,
                                                input int unsigned      tw);
    logic [DUE_W-1:0] mask;
    mask = (DUE_W'(1) << tw) - DUE_W'(1);
    return (due - now) & mask;
  endfunction

endpackage

// File: rtl/sop_edge_delay_queue.sv
// Ordered event queue: pop head, drop tail entries not earlier than the new one, push.
// A push into a full queue forces the head out first (ovf_pop).
module dly_event_queue
  import sop_dly_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  input  logic             push,
  input  logic             clear,
  input  logic             drop_en,
  input  logic [DUE_W-1:0] timer,
  input  logic [DUE_W-1:0] new_rem,
  input  dly_event_t       push_ev,
  output dly_event_t       head,
  output logic [CNTW-1:0]  cnt,
  output logic             ovf_pop
);

  dly_event_t      mem     [DEPTH];
  dly_event_t      mem_nxt [DEPTH];
  logic [CNTW-1:0] cnt_nxt;
  logic            full_after;
  int              p_off;
  int              n_keep;
  int              base;
  int              s_off;

  assign head = mem[0];

  always_comb begin
    p_off      = pop ? 1 : 0;
    n_keep     = 0;
    full_after = 1'b0;
    ovf_pop    = 1'b0;
    s_off      = 0;
    base       = 0;
    mem_nxt    = mem;
    cnt_nxt    = cnt;
    // Entries are sorted by remaining time, so the survivors form a prefix.
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= p_off && i < int'(cnt)) begin
        if (!(drop_en && rem_time(mem[i].due, timer, DW + 1) >= new_rem))
          n_keep++;
      end
    end
    full_after = (n_keep == DEPTH);
    ovf_pop    = push && full_after && !clear;
    s_off      = p_off + (ovf_pop ? 1 : 0);
    base       = n_keep - (ovf_pop ? 1 : 0);
    for (int j = 0; j < DEPTH; j++) begin
      if (j < base && j + s_off < DEPTH)
        mem_nxt[j] = mem[j + s_off];
      else if (j == base && push)
        mem_nxt[j] = push_ev;
    end
    cnt_nxt = clear ? '0 : CNTW'(base + (push ? 1 : 0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mem <= '{default: '0};
    end else begin
      cnt <= cnt_nxt;
      mem <= mem_nxt;
    end
  end

endmodule

// File: rtl/sop_edge_delay.sv
// y = OR(a_in & b_in) with programmable rise/fall delay in clock cycles, inertial or transport.
// Optional FILT_CNT_EN builds the saturating filtered-pulse counter; otherwise filt_cnt is 0.
module sop_edge_delay
  import sop_dly_pkg::*;
#(
  parameter int PAIRS = 2,
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAIRS-1:0] a_in,
  input  logic [PAIRS-1:0] b_in,
  input  logic [DW-1:0]    rise_dly,
  input  logic [DW-1:0]    fall_dly,
  input  logic             mode_transport,
  input  logic             ovf_clr,
  output logic             y_out,
  output logic             busy,
  output logic             ovf,
  output logic [CW-1:0]    filt_cnt
);

  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW:0]      timer;
  logic [DW:0]      due_new;
  logic             last_sched;
  dly_mode_e        mode_q;
  logic             f;
  logic             push_req;
  logic             fire;
  logic             pend_after;
  logic             cancel;
  logic             q_push;
  logic             ovf_pop;
  logic [DW-1:0]    d_raw;
  logic [DW-1:0]    d_eff;
  logic [CNTW-1:0]  cnt;
  dly_event_t       head;
  dly_event_t       push_ev;

  assign f          = |(a_in & b_in);
  assign push_req   = (f != last_sched);
  assign fire       = (cnt != '0) && (head.due == DUE_W'(timer));
  assign pend_after = (cnt != '0) && !(fire && cnt == CNTW'(1));
  // Inertial: a new edge while one is still pending means the pulse is too short.
  assign cancel     = push_req && (mode_q == MODE_INERTIAL) && pend_after;
  assign q_push     = push_req && !cancel;
  assign d_raw      = f ? rise_dly : fall_dly;
  assign d_eff      = (d_raw == '0) ? DW'(MIN_DLY) : d_raw;
  assign due_new    = timer + {1'b0, d_eff};
  assign push_ev    = '{val: f, due: DUE_W'(due_new)};
  assign busy       = (cnt != '0);

  dly_event_queue #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .pop     (fire),
    .push    (q_push),
    .clear   (cancel),
    .drop_en (mode_q == MODE_TRANSPORT),
    .timer   (DUE_W'(timer)),
    .new_rem (DUE_W'(d_eff)),
    .push_ev (push_ev),
    .head    (head),
    .cnt     (cnt),
    .ovf_pop (ovf_pop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      last_sched <= 1'b0;
      y_out      <= 1'b0;
      ovf        <= 1'b0;
      mode_q     <= MODE_INERTIAL;
    end else begin
      timer <= timer + (DW + 1)'(1);
      if (push_req)
        last_sched <= f;
      if (fire || ovf_pop)
        y_out <= head.val;
      if (ovf_pop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      // Mode only changes while nothing is in flight.
      if (!pend_after)
        mode_q <= mode_transport ? MODE_TRANSPORT : MODE_INERTIAL;
    end
  end

`ifdef FILT_CNT_EN
  logic [CW-1:0] filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      filt_q <= '0;
    else if (cancel && filt_q != '1)
      filt_q <= filt_q + CW'(1);
  end

  assign filt_cnt = filt_q;
`else
  assign filt_cnt = '0;
`endif

endmodule

// File: tb/tb_sop_edge_delay.sv
// Directed bench for sop_edge_delay (DEPTH=2 so the overflow path is reachable).
module tb_sop_edge_delay;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a_in = '0;
  logic [1:0] b_in = '0;
  logic [3:0] rise_dly = '0;
  logic [3:0] fall_dly = '0;
  logic       mode_transport = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       y_out;
  logic       busy;
  logic       ovf;
  logic [7:0] filt_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sop_edge_delay #(.PAIRS(2), .DW(4), .DEPTH(2), .CW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .a_in           (a_in),
    .b_in           (b_in),
    .rise_dly       (rise_dly),
    .fall_dly       (fall_dly),
    .mode_transport (mode_transport),
    .ovf_clr        (ovf_clr),
    .y_out          (y_out),
    .busy           (busy),
    .ovf            (ovf),
    .filt_cnt       (filt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic tr, input logic [3:0] r, input logic [3:0] fl);
    a_in = '0; b_in = '0; ovf_clr = 1'b0;
    mode_transport = tr; rise_dly = r; fall_dly = fl;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  logic [7:0] filt_exp;

  initial begin
`ifdef FILT_CNT_EN
    filt_exp = 8'd1;
`else
    filt_exp = 8'd0;
`endif
    #1;
    chk("rst_y", y_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_filt", filt_cnt, 0);

    // 1: inertial rise=3 fall=1
    do_reset(1'b0, 4'd3, 4'd1);
    a_in = 2'b01; b_in = 2'b01;
    step(1); chk("t1_e10_y", y_out, 0); chk("t1_e10_busy", busy, 1);
    step(2); chk("t1_e12_y", y_out, 0);
    step(1); chk("t1_e13_y", y_out, 1); chk("t1_e13_busy", busy, 0);
    step(6);
    b_in = 2'b00;
    step(1); chk("t1_e20_y", y_out, 1);
    step(1); chk("t1_e21_y", y_out, 0); chk("t1_e21_busy", busy, 0);

    // 2: inertial rise=4, two-cycle pulse swallowed
    do_reset(1'b0, 4'd4, 4'd4);
    a_in = 2'b10; b_in = 2'b10;
    step(2); chk("t2_e11_y", y_out, 0); chk("t2_e11_busy", busy, 1);
    b_in = 2'b00;
    step(1); chk("t2_e12_busy", busy, 0); chk("t2_filt", filt_cnt, 32'(filt_exp));
    step(4); chk("t2_e16_y", y_out, 0);

    // 3: transport rise=fall=4, pulse preserved
    do_reset(1'b1, 4'd4, 4'd4);
    a_in = 2'b01; b_in = 2'b01;
    step(2);
    b_in = 2'b00;
    step(1); chk("t3_e12_busy", busy, 1);
    step(2); chk("t3_e14_y", y_out, 1);
    step(1); chk("t3_e15_y", y_out, 1);
    step(1); chk("t3_e16_y", y_out, 0); chk("t3_e16_busy", busy, 0);
    chk("t3_filt", filt_cnt, 0);

    // 4: transport reorder, later rise dropped by earlier fall
    do_reset(1'b1, 4'd5, 4'd1);
    a_in = 2'b01; b_in = 2'b01;
    step(1); chk("t4_e10_busy", busy, 1);
    b_in = 2'b00;
    step(1); chk("t4_e11_y", y_out, 0); chk("t4_e11_busy", busy, 1);
    step(1); chk("t4_e12_y", y_out, 0); chk("t4_e12_busy", busy, 0);
    step(4); chk("t4_e16_y", y_out, 0);

    // 5: overflow with DEPTH=2
    do_reset(1'b1, 4'd8, 4'd8);
    a_in = 2'b01; b_in = 2'b01;
    step(1);
    b_in = 2'b00;
    step(1); chk("t5_e11_ovf", ovf, 0);
    b_in = 2'b01;
    step(1); chk("t5_e12_y", y_out, 1); chk("t5_e12_ovf", ovf, 1); chk("t5_e12_busy", busy, 1);
    step(6); chk("t5_e18_y", y_out, 1);
    step(1); chk("t5_e19_y", y_out, 0); chk("t5_e19_ovf", ovf, 1);
    ovf_clr = 1'b1;
    step(1); chk("t5_e20_ovf", ovf, 0); chk("t5_e20_y", y_out, 1); chk("t5_e20_busy", busy, 0);
    ovf_clr = 1'b0;

    // 6: reset in the middle of case 3 discards pending events
    do_reset(1'b1, 4'd4, 4'd4);
    a_in = 2'b01; b_in = 2'b01;
    step(2);
    b_in = 2'b00;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0); chk("t6_rst_y", y_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    step(1); chk("t6_e14_y", y_out, 0);
    step(2); chk("t6_e16_y", y_out, 0); chk("t6_e16_busy", busy, 0);

    // 7: zero delay behaves as one cycle
    do_reset(1'b0, 4'd0, 4'd0);
    a_in = 2'b11; b_in = 2'b01;
    step(1); chk("t7_e10_y", y_out, 0);
    step(1); chk("t7_e11_y", y_out, 1); chk("t7_e11_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
